// File: rtl/rv_instr_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the RV32I instruction encoder.
interface rv_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I encoder: packs decoded fields into instruction words behind a 2-entry FIFO.
module rv_instr_encoder (
  input logic               clk,
  input logic               rst_n,
  rv_instr_encoder_if.slave bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic signed [31:0] imm_p0;
  logic        [31:0] enc_instr_p0;
  logic               enc_err_p0;
  logic        [31:0] raw_instr_p0;

  logic [31:0] head_instr_p1, tail_instr_p1;
  logic        head_err_p1, tail_err_p1;
  logic [1:0]  count_p1, count_nxt;
  logic        in_ready_p1;
  logic [7:0]  err_count_p1;
  logic        push, pop;

  assign imm_p0 = $signed(bus.in_imm);

  // Stage p0: combinational packing and legality check of the offered bundle
  always_comb begin
    raw_instr_p0 = NOP;
    enc_err_p0   = 1'b0;
    case (bus.in_kind)
      4'd0: raw_instr_p0 = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0110011};
      4'd1, 4'd2, 4'd6: begin
        raw_instr_p0 = {imm_p0[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                        (bus.in_kind == 4'd1) ? 7'b0010011 :
                        (bus.in_kind == 4'd2) ? 7'b0000011 : 7'b1100111};
        enc_err_p0   = !in_range(imm_p0, -32'sd2048, 32'sd2047);
      end
      4'd3: begin
        raw_instr_p0 = {imm_p0[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm_p0[4:0], 7'b0100011};
        enc_err_p0   = !in_range(imm_p0, -32'sd2048, 32'sd2047);
      end
      4'd4: begin
        raw_instr_p0 = {imm_p0[12], imm_p0[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm_p0[4:1], imm_p0[11], 7'b1100011};
        enc_err_p0   = !in_range(imm_p0, -32'sd4096, 32'sd4094) || imm_p0[0];
      end
      4'd5: begin
        raw_instr_p0 = {imm_p0[20], imm_p0[10:1], imm_p0[11], imm_p0[19:12], bus.in_rd, 7'b1101111};
        enc_err_p0   = !in_range(imm_p0, -32'sd1048576, 32'sd1048574) || imm_p0[0];
      end
      4'd7, 4'd8: begin
        raw_instr_p0 = {imm_p0[31:12], bus.in_rd, (bus.in_kind == 4'd7) ? 7'b0110111 : 7'b0010111};
        enc_err_p0   = (imm_p0[11:0] != 12'd0);
      end
      default: enc_err_p0 = 1'b1;
    endcase
  end

  assign enc_instr_p0 = enc_err_p0 ? NOP : raw_instr_p0;

  assign push = bus.in_valid & in_ready_p1;
  assign pop  = (count_p1 != 2'd0) & bus.out_ready;

  always_comb begin
    count_nxt = count_p1;
    if (push && !pop)      count_nxt = count_p1 + 2'd1;
    else if (pop && !push) count_nxt = count_p1 - 2'd1;
  end

  // Stage p1: FIFO storage; head is always the visible output entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_p1      <= 2'd0;
      in_ready_p1   <= 1'b1;
      err_count_p1  <= 8'd0;
      head_instr_p1 <= 32'd0;
      head_err_p1   <= 1'b0;
      tail_instr_p1 <= 32'd0;
      tail_err_p1   <= 1'b0;
    end else begin
      count_p1    <= count_nxt;
      in_ready_p1 <= (count_nxt != 2'd2);
      if (push && enc_err_p0)
        err_count_p1 <= sat_inc(err_count_p1);
      if (push && ((count_p1 == 2'd0) || (count_p1 == 2'd1 && pop))) begin
        head_instr_p1 <= enc_instr_p0;
        head_err_p1   <= enc_err_p0;
      end else if (pop && count_p1 == 2'd2) begin
        head_instr_p1 <= tail_instr_p1;
        head_err_p1   <= tail_err_p1;
      end
      if (push && !pop && count_p1 == 2'd1) begin
        tail_instr_p1 <= enc_instr_p0;
        tail_err_p1   <= enc_err_p0;
      end
    end
  end

  assign bus.in_ready  = in_ready_p1;
  assign bus.out_valid = (count_p1 != 2'd0);
  assign bus.out_instr = head_instr_p1;
  assign bus.out_err   = head_err_p1;
  assign bus.err_count = err_count_p1;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Randomized and directed bench for rv_instr_encoder against a queue-based reference model.
module tb_rv_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rv_instr_encoder_if bus ();
  rv_instr_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    bit [31:0] w;
    bit        e;
  } ent_t;

  ent_t q[$];
  ent_t head;
  int   m_errs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] fld(input bit [31:0] u, input int hi, input int lo);
    return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference encoder: field arithmetic straight from the instruction formats
  function automatic void model_enc(input int kind, input bit [31:0] rd, input bit [31:0] rs1,
                                    input bit [31:0] rs2, input bit [31:0] f3, input bit [31:0] f7,
                                    input bit [31:0] u, output bit [31:0] w, output bit e);
    bit [31:0] ops[9] = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h63, 32'h6F, 32'h67, 32'h37, 32'h17};
    int s = int'(u);
    bit [31:0] regs = (rs1 << 15) + (f3 << 12);
    e = 1'b0;
    w = 32'h13;
    if (kind > 8) begin
      e = 1'b1;
      return;
    end
    case (kind)
      0: w = (f7 << 25) + (rs2 << 20) + regs + (rd << 7) + ops[0];
      1, 2, 6: begin
        w = (fld(u, 11, 0) << 20) + regs + (rd << 7) + ops[kind];
        e = (s < -2048) || (s > 2047);
      end
      3: begin
        w = (fld(u, 11, 5) << 25) + (rs2 << 20) + regs + (fld(u, 4, 0) << 7) + ops[3];
        e = (s < -2048) || (s > 2047);
      end
      4: begin
        w = (fld(u, 12, 12) << 31) + (fld(u, 10, 5) << 25) + (rs2 << 20) + regs
            + (fld(u, 4, 1) << 8) + (fld(u, 11, 11) << 7) + ops[4];
        e = (s < -4096) || (s > 4094) || (s % 2 != 0);
      end
      5: begin
        w = (fld(u, 20, 20) << 31) + (fld(u, 10, 1) << 21) + (fld(u, 11, 11) << 20)
            + (fld(u, 19, 12) << 12) + (rd << 7) + ops[5];
        e = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      end
      default: begin
        w = (fld(u, 31, 12) << 12) + (rd << 7) + ops[kind];
        e = (fld(u, 11, 0) != 0);
      end
    endcase
    if (e) w = 32'h13;
  endfunction

  task automatic set_bundle(input int kind, input int rd, input int rs1, input int rs2,
                            input int f3, input int f7, input bit [31:0] imm);
    bus.in_kind   = kind[3:0];
    bus.in_rd     = rd[4:0];
    bus.in_rs1    = rs1[4:0];
    bus.in_rs2    = rs2[4:0];
    bus.in_funct3 = f3[2:0];
    bus.in_funct7 = f7[6:0];
    bus.in_imm    = imm;
  endtask

  task automatic model_reset();
    q.delete();
    head   = '{w: 32'd0, e: 1'b0};
    m_errs = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(q.size() < 2));
    chk({tag, ".out_instr"}, bus.out_instr,      head.w);
    chk({tag, ".out_err"},   32'(bus.out_err),   32'(head.e));
    chk({tag, ".err_count"}, 32'(bus.err_count), 32'(m_errs));
  endtask

  // One clock: model follows the edge using the pre-edge state, outputs compared on the falling edge
  task automatic cycle(input string tag);
    ent_t ne;
    bit acc, pp;
    @(posedge clk);
    acc = bus.in_valid && (q.size() < 2);
    pp  = (q.size() > 0) && bus.out_ready;
    if (acc) model_enc(int'(bus.in_kind), 32'(bus.in_rd), 32'(bus.in_rs1), 32'(bus.in_rs2),
                       32'(bus.in_funct3), 32'(bus.in_funct7), bus.in_imm, ne.w, ne.e);
    if (pp) void'(q.pop_front());
    if (acc) begin
      q.push_back(ne);
      if (ne.e && m_errs < 255) m_errs++;
    end
    if (q.size() > 0) head = q[0];
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic push1(input string tag, input bit [31:0] exp_w, input bit exp_e);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cycle(tag);
    bus.in_valid = 1'b0;
    chk({tag, ".word"}, bus.out_instr, exp_w);
    chk({tag, ".err"},  32'(bus.out_err), 32'(exp_e));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit [31:0] rand_imm();
    case ($urandom_range(4))
      0: return $urandom;
      1: return 32'($urandom_range(4099) - 2050);
      2: return 32'($urandom_range(8199) - 4100);
      3: return 32'($urandom_range(2097159) - 1048580);
      default: return $urandom & ($urandom_range(1) ? 32'hFFFF_F000 : 32'hFFFF_FFFF);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_bundle(0, 0, 0, 0, 0, 0, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("por");
    rst_n = 1'b1;

    set_bundle(1, 1, 2, 0, 0, 0, 32'hFFFF_FFFF);  push1("addi", 32'hFFF1_0093, 1'b0);
    set_bundle(3, 0, 2, 5, 2, 0, 32'd8);          push1("sw",   32'h0051_2423, 1'b0);
    set_bundle(4, 0, 0, 0, 0, 0, -32'sd4);        push1("beq",  32'hFE00_0EE3, 1'b0);
    set_bundle(5, 1, 0, 0, 0, 0, 32'd2048);       push1("jal",  32'h0010_00EF, 1'b0);
    set_bundle(7, 5, 0, 0, 0, 0, 32'h1234_5000);  push1("lui",  32'h1234_52B7, 1'b0);
    set_bundle(0, 3, 4, 5, 0, 32, 32'd0);         push1("sub",  32'h4052_01B3, 1'b0);

    set_bundle(1, 1, 2, 0, 0, 0, 32'd2048);       push1("e_imm",  32'h13, 1'b1);
    set_bundle(4, 0, 0, 0, 0, 0, 32'd3);          push1("e_br",   32'h13, 1'b1);
    set_bundle(7, 5, 0, 0, 0, 0, 32'h1234_5001);  push1("e_lui",  32'h13, 1'b1);
    set_bundle(12, 1, 1, 1, 1, 1, 32'd0);         push1("e_kind", 32'h13, 1'b1);
    chk("err_count4", 32'(bus.err_count), 32'd4);
    cycle("drain");
    for (int i = 0; i < 260; i++) begin
      set_bundle(9 + (i % 7), i % 32, 0, 0, 0, 0, 32'd0);
      bus.in_valid = 1'b1;
      cycle("sat");
    end
    bus.in_valid = 1'b0;
    chk("err_sat", 32'(bus.err_count), 32'd255);
    cycle("idle");

    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_bundle(1, 1, 2, 0, 0, 0, 32'd1); cycle("bp_a");
    set_bundle(1, 1, 2, 0, 0, 0, 32'd2); cycle("bp_b");
    set_bundle(1, 1, 2, 0, 0, 0, 32'd3); cycle("bp_c");
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head", bus.out_instr, 32'h0011_0093);
    bus.out_ready = 1'b1;
    cycle("bp_pop1");
    chk("bp_word_b", bus.out_instr, 32'h0021_0093);
    cycle("bp_pop2");
    chk("bp_word_c", bus.out_instr, 32'h0031_0093);
    bus.in_valid = 1'b0;
    cycle("bp_pop3");
    chk("bp_empty", 32'(bus.out_valid), 32'd0);
    chk("bp_hold", bus.out_instr, 32'h0031_0093);

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_bundle(13, 0, 0, 0, 0, 0, 32'd0); cycle("rq_a");
    set_bundle(8, 7, 0, 0, 0, 0, 32'hABCD_E000); cycle("rq_b");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_errs",  32'(bus.err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_bundle(1, 9, 9, 0, 0, 0, 32'd5);
    cycle("rst_new");
    bus.in_valid  = 1'b0;
    chk("rst_new_word", bus.out_instr, 32'h0054_8493);
    bus.out_ready = 1'b1;
    cycle("rst_pop");
    chk("rst_only_new", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 600; i++) begin
      set_bundle($urandom_range(15), $urandom_range(31), $urandom_range(31), $urandom_range(31),
                 $urandom_range(7), $urandom_range(127), rand_imm());
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(2) != 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
